// File: rtl/uart_tx_buffer_pkg.sv
// Shared constants for the buffered UART transmitter: MMIO addresses,
// enable levels and the transmit FSM state encoding.
package uart_tx_buffer_pkg;

    localparam logic [31:0] UART_ADDR        = 32'h1000_0000;
    localparam logic [31:0] UART_STATUS_ADDR = 32'h1000_0004;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [1:0] {
        UTX_IDLE  = 2'd0,
        UTX_START = 2'd1,
        UTX_DATA  = 2'd2,
        UTX_STOP  = 2'd3
    } utx_state_t;

endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Synchronous FIFO with registered show-ahead output: o_dout always holds
// the current head, so a pop and a use of the head can share a cycle.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_dout;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    w_rd_ptr_next;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;
    logic             r_full;
    logic             r_empty;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok     = i_push && !r_full;
    assign w_pop_ok      = i_pop && !r_empty;
    assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop_ok);

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_rd_ptr <= w_rd_ptr_next;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // A write landing on the next head slot must bypass the array read.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
        if (w_push_ok && (r_wr_ptr == w_rd_ptr_next)) begin
            r_dout <= i_din;
        end else begin
            r_dout <= r_mem[w_rd_ptr_next];
        end
    end

    assign o_dout  = r_dout;
    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter: MMIO byte stores queue in a FIFO and are
// shifted out LSB first; status outputs expose fill level and overflow.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int  CLKS_PER_BIT = 868,
    parameter int  DEPTH        = 16,
    localparam int CW           = $clog2(DEPTH + 1),
    localparam int TW           = $clog2(CLKS_PER_BIT)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [7:0]    i_wr_data,
    input  logic          i_ovf_clr,
    output logic          o_uart_tx,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count,
    output logic          o_busy,
    output logic          o_overflow
);

    utx_state_t    r_state;
    logic [TW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;
    logic          r_overflow;

    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_bit_end;
    logic          w_pop;
    logic          w_push_ok;

    assign w_bit_end = (r_clk_cnt == TW'(CLKS_PER_BIT - 1));
    assign w_pop     = ((r_state == UTX_IDLE) || ((r_state == UTX_STOP) && w_bit_end)) && !w_empty;
    assign w_push_ok = i_wr_en && !w_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .i_push  (i_wr_en),
        .i_pop   (w_pop),
        .i_din   (i_wr_data),
        .o_dout  (w_head),
        .o_count (o_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Busy looks one cycle ahead so it is registered yet tracks the frame exactly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= UTX_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= DISABLE;
        end else begin
            case (r_state)
                UTX_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= !w_empty || w_push_ok;
                    if (!w_empty) begin
                        r_shift   <= w_head;
                        r_bit_idx <= '0;
                        r_clk_cnt <= '0;
                        r_tx      <= 1'b0;
                        r_state   <= UTX_START;
                    end
                end
                UTX_START: begin
                    r_busy <= ENABLE;
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= UTX_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + TW'(1);
                    end
                end
                UTX_DATA: begin
                    r_busy <= ENABLE;
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= UTX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + TW'(1);
                    end
                end
                UTX_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (!w_empty) begin
                            r_shift   <= w_head;
                            r_bit_idx <= '0;
                            r_tx      <= 1'b0;
                            r_busy    <= ENABLE;
                            r_state   <= UTX_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_busy  <= w_push_ok;
                            r_state <= UTX_IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + TW'(1);
                        r_busy    <= ENABLE;
                    end
                end
                default: begin
                    r_state <= UTX_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // A dropped write takes priority over a clear in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= DISABLE;
        end else if (i_wr_en && w_full) begin
            r_overflow <= ENABLE;
        end else if (i_ovf_clr) begin
            r_overflow <= DISABLE;
        end
    end

    assign o_uart_tx  = r_tx;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_busy     = r_busy;
    assign o_overflow = r_overflow;

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Buffered UART transmitter on the memory-access stage's MMIO path. Byte stores to the UART data address go into a DEPTH-entry FIFO and are serialised as 8N1 frames on `uart_tx`, so back-to-back stores are not lost while a frame is in flight. Status outputs feed the load-value mux, so software can poll fill level and overflow.

## Interface

Parameters:

- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Must be ≥ 2.
- `DEPTH`, default 16: FIFO entries. Must be a power of two, ≥ 2.

Ports:

- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  store to `UART_ADDR` in the memory-access stage; one byte per cycle.
- `wr_data`  in  8  byte to send (`ma_store_value_raw[7:0]`).
- `ovf_clr`  in  1  clears the sticky overflow flag; driven by a store to `UART_STATUS_ADDR`.
- `uart_tx`  out  1  serial line; idle high.
- `full`  out  1  FIFO count == DEPTH.
- `empty`  out  1  FIFO count == 0.
- `count`  out  $clog2(DEPTH+1)  current FIFO occupancy.
- `busy`  out  1  a frame is in progress, or the FIFO is non-empty.
- `overflow`  out  1  sticky flag: a write was dropped.

## Operation

- Reset values: `uart_tx`=1, `count`=0, `empty`=1, `full`=0, `busy`=0, `overflow`=0, FSM in IDLE.
- **Write acceptance**
  - A write is accepted iff `wr_en` && !`full`, where `full` is the registered value.
  - A same-cycle pop does not rescue a write attempted while `full`=1.
  - A dropped write sets `overflow`.
- **Overflow flag**
  - `ovf_clr` clears `overflow`.
  - If a set and a clear occur in the same cycle, the set wins.
- **Count**
  - Increments on an accepted write and decrements on a pop.
  - A simultaneous accepted write and pop leaves it unchanged.
  - Read/write pointers are log2(DEPTH) bits wide and wrap naturally.
- **Data order**: FIFO order; each byte is sent LSB first.
- **Transmit FSM states**: IDLE, START, DATA, STOP.
  - IDLE: if !`empty`, pop the head into the shift register, load the bit counter with 0, and go to START. Otherwise stay in IDLE with `uart_tx`=1.
  - START: `uart_tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `uart_tx`=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. Go to STOP after 8 bits.
  - STOP: `uart_tx`=1 for CLKS_PER_BIT cycles.
    - At the end of STOP, if !`empty`, pop and go directly to START, with no idle cycle between frames.
    - Otherwise go to IDLE.
- **Output register**: `uart_tx` is registered and driven only from FSM state and the shift register; no glitches.
- **Reset mid-frame**: `uart_tx` goes to 1 asynchronously, the FIFO is emptied, and the partial frame is discarded.

## Timing

- Write at edge N:
  - `count`/`empty` update at N+1.
  - The FSM pops at N+1 (if in IDLE).
  - `uart_tx` falls at N+2.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames repeat with a period of exactly 10·CLKS_PER_BIT.
- The bit-time counter is $clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1.
- `busy` is registered and deasserts in the cycle after the last stop-bit cycle when the FIFO is empty.
- The status word returned on a load from `UART_STATUS_ADDR` is {overflow, full, empty, busy, count}, zero-extended to 32 bits. It is assembled in the load mux, not in this block.

## Structure

- `define.vh` holds:
  - `UART_ADDR` and `UART_STATUS_ADDR`;
  - the FSM state encodings `UTX_IDLE`, `UTX_START`, `UTX_DATA`, `UTX_STOP` (2-bit);
  - `ENABLE`/`DISABLE`.
- Sub-module `sync_fifo` (parameters WIDTH and DEPTH):
  - ports: push, pop, din, dout, count, full, empty;
  - `dout` is registered, with a show-ahead head.
- The FSM, bit-time counter, and shifter live in the top of this block.

## Test plan

All scenarios use CLKS_PER_BIT=4 and DEPTH=4.

- **Reset**: assert `rst_n`=0 mid-stream → `uart_tx`=1, `count`=0, `empty`=1, `overflow`=0 in the same cycle. After release, the line stays high with no spurious frame.
- **Single byte**: write 0x55 at cycle 0 → `uart_tx` low over cycles 2-5, then 1,0,1,0,1,0,1,0 in 4-cycle bits, stop high over cycles 38-41. `busy` is 0 from cycle 42.
- **Back-to-back**: write 0xA3 then 0x0F in consecutive cycles → two frames 40 cycles apart with no idle gap. Decoded bytes are 0xA3 then 0x0F.
- **Overflow**: six consecutive writes 0x01..0x06 → the first is popped at cycle 1. `full`=1 after the fifth write, the sixth is dropped, and `overflow`=1. Bytes 0x01..0x05 are sent in order.
- **Overflow set/clear race**: `ovf_clr` in the same cycle as a dropped write → `overflow` stays 1. A later `ovf_clr` alone → 0.
- **Wrap-around**: 10 writes paced so the FIFO never fills → pointers wrap twice, all 10 bytes are sent in order, and `overflow`=0.
